seg7_scan_display: RTL and testbench
====================================

SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each digit is driven; legal range 2..65535.
REQ-002 Parameter BLANK_CYC, default 8: all-off cycles between digits; legal range 1..255.
REQ-003 Parameter COMMON_ANODE, default 0: 0 means seg/an active-high, 1 means seg/an active-low.
REQ-004 Parameter SUPPRESS_ZERO, default 1: 1 means tens digit stays dark when the tens value is 0.
REQ-005 clki  input  1  sole clock; all state updates on rising edge.
REQ-006 rs  input  1  reset; synchronous, active-low.
REQ-007 q_in  input  4  unsigned 0..15 count from the upstream 4-bit counter; sampled every edge.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}.
REQ-009 an  output  2  digit enables; an[0] ones digit, an[1] tens digit.
REQ-010 wrap  output  1  one-cycle pulse on a count roll-over from 15 to 0.
REQ-011 wrap_cnt  output  8  number of roll-overs since reset, modulo 256.

Function
REQ-012 q_in SHALL be registered into q_reg every edge; no combinational path from q_in to any output.
REQ-013 Scan FSM SHALL cycle S_ONES(SCAN_DIV cycles) -> S_GAP0(BLANK_CYC) -> S_TENS(SCAN_DIV) -> S_GAP1(BLANK_CYC) -> S_ONES; frame = 2*(SCAN_DIV+BLANK_CYC) cycles.
REQ-014 Timer SHALL count 0..N-1 in each state; state advances and timer clears on the edge where timer = N-1.
REQ-015 Snapshot register SHALL load q_reg on the S_GAP1 -> S_ONES transition only; q_in changes mid-frame SHALL NOT alter the digits shown in that frame.
REQ-016 BCD split of snapshot: tens = 1 and ones = snapshot-10 if snapshot >= 10, else tens = 0 and ones = snapshot.
REQ-017 Active-high digit patterns 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
REQ-018 In S_ONES: an = ones enable, seg = pattern(ones).
REQ-019 In S_TENS: an = tens enable, seg = pattern(tens); if SUPPRESS_ZERO=1 and tens=0, an and seg SHALL be all inactive.
REQ-020 In S_GAP0/S_GAP1: an and seg SHALL be all inactive.
REQ-021 seg and an SHALL be registered; they reflect the FSM state and snapshot of the preceding cycle (one-cycle output latency).
REQ-022 COMMON_ANODE=1 SHALL bitwise-invert both seg and an relative to the active-high encoding, including the inactive (off) level.
REQ-023 wrap SHALL be high for exactly the one cycle following the edge at which q_reg = 15 and q_in = 0 are seen together.
REQ-024 Any other transition (e.g. 15->3, 14->0, 0->0) SHALL NOT assert wrap.
REQ-025 wrap_cnt SHALL increment by 1 on the same edge that sets wrap; 255 + 1 wraps to 0.
REQ-026 Out-of-range parameter values are unsupported; no runtime checking required.

Reset
REQ-027 When rs = 0 at a rising edge, the block SHALL load: state S_ONES, timer 0, q_reg 0, snapshot 0, wrap 0, wrap_cnt 0, seg/an inactive.
REQ-028 Reset SHALL take priority over every other update, including assertion mid-state or mid-wrap-pulse.
REQ-029 First frame after release SHALL show digit 0 on ones; tens is dark when SUPPRESS_ZERO=1.
REQ-030 q_reg = 0 after reset; q_in = 0 on the first post-reset edge SHALL NOT produce wrap.

Verification
All scenarios use SCAN_DIV=4, BLANK_CYC=1, COMMON_ANODE=0, SUPPRESS_ZERO=1 unless stated otherwise.
REQ-031 Reset: rs=0 for 2 edges, q_in=0 -> seg=00, an=00, wrap=0, wrap_cnt=00; after release seg=3F and an=01 for 4 cycles, then an=00 for 1 cycle, then an=00 for 4 cycles (tens suppressed).
REQ-032 Two-digit value: q_in=13 held for 2 frames -> second frame shows ones seg=4F/an=01 for 4 cycles, then 1 gap cycle, then tens seg=06/an=10 for 4 cycles.
REQ-033 Coherence: q_in steps 12->14 during S_ONES -> that frame still shows 2/1; the next frame shows 4/1.
REQ-034 Wrap: q_in 14,15,0,1 on consecutive edges -> wrap high exactly 1 cycle and wrap_cnt 00->01; sequence 15,3 -> no pulse; 256 roll-overs -> wrap_cnt returns to 00.
REQ-035 Mid-operation reset: rs=0 for one edge during S_TENS with wrap_cnt=05 -> next cycle seg/an inactive and wrap_cnt=00; the scan restarts at S_ONES with a full 4-cycle ones digit.
REQ-036 Polarity: COMMON_ANODE=1, q_in=8 -> ones phase seg=00, an=10; gap phases seg=7F, an=11.

Source files
------------

// File: rtl/seg7_scan_display.sv
// Two-digit multiplexed 7-segment driver for a 4-bit counter value (0..15).
// Scans ones digit, blank gap, tens digit, blank gap; latches the value once
// per frame so a frame never shows a torn number. Also flags 15->0 roll-overs
// and counts them.
module seg7_scan_display #(
  parameter int SCAN_DIV      = 1000,
  parameter int BLANK_CYC     = 8,
  parameter int COMMON_ANODE  = 0,
  parameter int SUPPRESS_ZERO = 1
) (
  input  logic       clki,
  input  logic       rs,
  input  logic [3:0] q_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       wrap,
  output logic [7:0] wrap_cnt
);

  typedef enum logic [1:0] {
    S_ONES = 2'd0,
    S_GAP0 = 2'd1,
    S_TENS = 2'd2,
    S_GAP1 = 2'd3
  } state_t;

  // Terminal timer values for the digit and blank phases.
  localparam logic [15:0] DIGIT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] GAP_LAST   = 16'(BLANK_CYC - 1);

  // Off level of the pins depends on the display polarity.
  localparam logic [6:0] SEG_OFF = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF  = (COMMON_ANODE != 0) ? 2'b11 : 2'b00;

  state_t      state;
  state_t      state_next;
  logic [15:0] timer;
  logic [15:0] timer_next;
  logic        load_snap;

  logic [3:0]  q_reg;
  logic [3:0]  snapshot;
  logic [3:0]  ones;
  logic        tens;
  logic        wrap_next;

  logic [6:0]  seg_hi;
  logic [1:0]  an_hi;
  logic [6:0]  seg_next;
  logic [1:0]  an_next;

  // Active-high segment pattern {g,f,e,d,c,b,a} for a decimal digit.
  function automatic logic [6:0] digit_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // Scan state register and per-phase timer.
  always_ff @(posedge clki) begin
    if (!rs) begin
      state <= S_ONES;
      timer <= 16'd0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // Next-state logic: each phase lasts until its timer hits the terminal value.
  always_comb begin
    state_next = state;
    timer_next = timer + 16'd1;
    load_snap  = 1'b0;
    case (state)
      S_ONES: begin
        if (timer == DIGIT_LAST) begin
          state_next = S_GAP0;
          timer_next = 16'd0;
        end
      end
      S_GAP0: begin
        if (timer == GAP_LAST) begin
          state_next = S_TENS;
          timer_next = 16'd0;
        end
      end
      S_TENS: begin
        if (timer == DIGIT_LAST) begin
          state_next = S_GAP1;
          timer_next = 16'd0;
        end
      end
      S_GAP1: begin
        if (timer == GAP_LAST) begin
          state_next = S_ONES;
          timer_next = 16'd0;
          load_snap  = 1'b1;
        end
      end
      default: begin
        state_next = S_ONES;
        timer_next = 16'd0;
      end
    endcase
  end

  // Roll-over happens when the previous count was 15 and the new one is 0.
  always_comb begin
    wrap_next = (q_reg == 4'd15) && (q_in == 4'd0);
  end

  // Input register, frame snapshot and roll-over flag/counter.
  always_ff @(posedge clki) begin
    if (!rs) begin
      q_reg    <= 4'd0;
      snapshot <= 4'd0;
      wrap     <= 1'b0;
      wrap_cnt <= 8'd0;
    end else begin
      q_reg <= q_in;
      if (load_snap) begin
        snapshot <= q_reg;
      end
      wrap <= wrap_next;
      if (wrap_next) begin
        wrap_cnt <= wrap_cnt + 8'd1;
      end
    end
  end

  // Split the 0..15 snapshot into a tens bit and a ones digit.
  always_comb begin
    if (snapshot >= 4'd10) begin
      tens = 1'b1;
      ones = snapshot - 4'd10;
    end else begin
      tens = 1'b0;
      ones = snapshot;
    end
  end

  // Select the active-high pin image for the current phase, then apply polarity.
  always_comb begin
    seg_hi = 7'h00;
    an_hi  = 2'b00;
    case (state)
      S_ONES: begin
        seg_hi = digit_pattern(ones);
        an_hi  = 2'b01;
      end
      S_TENS: begin
        if (!((SUPPRESS_ZERO != 0) && !tens)) begin
          seg_hi = digit_pattern({3'b000, tens});
          an_hi  = 2'b10;
        end
      end
      default: begin
        seg_hi = 7'h00;
        an_hi  = 2'b00;
      end
    endcase
    if (COMMON_ANODE != 0) begin
      seg_next = ~seg_hi;
      an_next  = ~an_hi;
    end else begin
      seg_next = seg_hi;
      an_next  = an_hi;
    end
  end

  // Registered display pins so they never glitch on state changes.
  always_ff @(posedge clki) begin
    if (!rs) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: a frame-position model predicts every output
// each cycle for an active-high and an active-low instance; directed phases
// pin the model with literal values, then randomized counts and resets follow.
module tb_seg7_scan_display;

  localparam int D     = 4;
  localparam int B     = 1;
  localparam int FRAME = 2 * (D + B);

  logic       clki;
  logic       rs;
  logic [3:0] q_in;
  logic [6:0] seg, seg_ca;
  logic [1:0] an, an_ca;
  logic       wrap, wrap_ca;
  logic [7:0] wrap_cnt, cnt_ca;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  bit         m_valid = 0;
  int         m_pos;
  int         m_q;
  int         m_snap;
  logic [6:0] e_seg;
  logic [1:0] e_an;
  logic       e_wrap;
  logic [7:0] e_cnt;

  seg7_scan_display #(
    .SCAN_DIV(D), .BLANK_CYC(B), .COMMON_ANODE(0), .SUPPRESS_ZERO(1)
  ) dut (
    .clki(clki), .rs(rs), .q_in(q_in),
    .seg(seg), .an(an), .wrap(wrap), .wrap_cnt(wrap_cnt)
  );

  seg7_scan_display #(
    .SCAN_DIV(D), .BLANK_CYC(B), .COMMON_ANODE(1), .SUPPRESS_ZERO(1)
  ) dut_ca (
    .clki(clki), .rs(rs), .q_in(q_in),
    .seg(seg_ca), .an(an_ca), .wrap(wrap_ca), .wrap_cnt(cnt_ca)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  task automatic compareVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-position model: output after an edge depends on where that edge
  // sits in the frame and on the value latched at the previous frame boundary.
  always @(posedge clki) begin
    int p, o, t;
    if (!rs) begin
      m_pos = 0; m_q = 0; m_snap = 0;
      e_seg = 7'h00; e_an = 2'b00; e_wrap = 1'b0; e_cnt = 8'd0;
      m_valid = 1;
    end else begin
      p = m_pos % FRAME;
      o = m_snap % 10;
      t = m_snap / 10;
      if (p < D) begin
        e_seg = pat[o]; e_an = 2'b01;
      end else if (p >= D + B && p < 2 * D + B && t != 0) begin
        e_seg = pat[t]; e_an = 2'b10;
      end else begin
        e_seg = 7'h00; e_an = 2'b00;
      end
      if (p == FRAME - 1) m_snap = m_q;
      m_pos++;
      e_wrap = (m_q == 15) && (q_in == 4'd0);
      if (e_wrap) e_cnt = e_cnt + 8'd1;
      m_q = int'(q_in);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clki) begin
    if (m_valid) begin
      compareVal("seg",     {1'b0, seg},     {1'b0, e_seg});
      compareVal("an",      {6'd0, an},      {6'd0, e_an});
      compareVal("wrap",    {7'd0, wrap},    {7'd0, e_wrap});
      compareVal("cnt",     wrap_cnt,        e_cnt);
      compareVal("seg_ca",  {1'b0, seg_ca},  {1'b0, ~e_seg});
      compareVal("an_ca",   {6'd0, an_ca},   {6'd0, ~e_an});
      compareVal("wrap_ca", {7'd0, wrap_ca}, {7'd0, e_wrap});
      compareVal("cnt_ca",  cnt_ca,          e_cnt);
    end
  end

  // Drive inputs just after an edge, let the next edge sample them, and
  // return 1 time unit after that edge so outputs reflect it.
  task automatic applyStimulus(input logic r, input logic [3:0] q);
    rs   = r;
    q_in = q;
    @(posedge clki);
    #1;
  endtask

  task automatic checkOutput(input string name, input bit ca,
                             input logic [6:0] es, input logic [1:0] ea);
    if (ca) begin
      compareVal({name, ".seg"}, {1'b0, seg_ca}, {1'b0, es});
      compareVal({name, ".an"},  {6'd0, an_ca},  {6'd0, ea});
    end else begin
      compareVal({name, ".seg"}, {1'b0, seg}, {1'b0, es});
      compareVal({name, ".an"},  {6'd0, an},  {6'd0, ea});
    end
  endtask

  task automatic checkWrap(input string name, input logic ew, input logic [7:0] ec);
    compareVal({name, ".wrap"}, {7'd0, wrap}, {7'd0, ew});
    compareVal({name, ".cnt"},  wrap_cnt,     ec);
  endtask

  initial begin
    rs   = 1'b0;
    q_in = 4'd0;

    // Reset and first frame: 0 on ones, tens suppressed.
    applyStimulus(1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0);
    checkOutput("reset", 1'b0, 7'h00, 2'b00);
    checkWrap("reset", 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 4'd0);
      if (i == 0 || i == 3) checkOutput("first_ones", 1'b0, 7'h3F, 2'b01);
      if (i == 4) checkOutput("first_gap", 1'b0, 7'h00, 2'b00);
      if (i == 5 || i == 8) checkOutput("first_tens_dark", 1'b0, 7'h00, 2'b00);
    end
    checkWrap("no_wrap_after_reset", 1'b0, 8'h00);

    // Two-digit value 13 shows in the second frame.
    applyStimulus(1'b0, 4'd13);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 4'd13);
      if (i == 10 || i == 13) checkOutput("v13_ones", 1'b0, 7'h4F, 2'b01);
      if (i == 14) checkOutput("v13_gap", 1'b0, 7'h00, 2'b00);
      if (i == 15 || i == 18) checkOutput("v13_tens", 1'b0, 7'h06, 2'b10);
    end

    // Mid-frame change 12 -> 14 must not tear the frame.
    applyStimulus(1'b0, 4'd12);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, (i < 12) ? 4'd12 : 4'd14);
      if (i == 12) checkOutput("coh_ones12", 1'b0, 7'h5B, 2'b01);
      if (i == 15) checkOutput("coh_tens12", 1'b0, 7'h06, 2'b10);
      if (i == 20) checkOutput("coh_ones14", 1'b0, 7'h66, 2'b01);
      if (i == 25) checkOutput("coh_tens14", 1'b0, 7'h06, 2'b10);
    end

    // Roll-over detection and counter.
    applyStimulus(1'b1, 4'd14);
    applyStimulus(1'b1, 4'd15);
    checkWrap("pre_wrap", 1'b0, 8'h00);
    applyStimulus(1'b1, 4'd0);
    checkWrap("wrap_pulse", 1'b1, 8'h01);
    applyStimulus(1'b1, 4'd1);
    checkWrap("wrap_end", 1'b0, 8'h01);
    applyStimulus(1'b1, 4'd15);
    applyStimulus(1'b1, 4'd3);
    checkWrap("no_wrap_15_3", 1'b0, 8'h01);
    for (int i = 0; i < 255; i++) begin
      applyStimulus(1'b1, 4'd15);
      applyStimulus(1'b1, 4'd0);
    end
    checkWrap("cnt_wrap_256", 1'b1, 8'h00);

    // Reset in the middle of the tens phase with five roll-overs counted.
    applyStimulus(1'b0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'd15);
      applyStimulus(1'b1, 4'd0);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'd0);
    checkOutput("mid_tens", 1'b0, 7'h06, 2'b10);
    checkWrap("mid_cnt5", 1'b0, 8'h05);
    applyStimulus(1'b0, 4'd0);
    checkOutput("mid_reset", 1'b0, 7'h00, 2'b00);
    checkWrap("mid_reset", 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'd0);
      if (i < 4) checkOutput("restart_ones", 1'b0, 7'h3F, 2'b01);
      else checkOutput("restart_gap", 1'b0, 7'h00, 2'b00);
    end

    // Active-low instance showing 8.
    applyStimulus(1'b0, 4'd8);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, 4'd8);
      if (i == 0) checkOutput("ca_ones0", 1'b1, 7'h40, 2'b10);
      if (i == 4) checkOutput("ca_gap", 1'b1, 7'h7F, 2'b11);
      if (i == 10) checkOutput("ca_ones8", 1'b1, 7'h00, 2'b10);
    end

    // Randomized counts biased toward roll-overs, with occasional resets.
    applyStimulus(1'b0, 4'd0);
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic [3:0] q;
      int         sel;
      r   = ($urandom_range(0, 299) != 0);
      sel = int'($urandom_range(0, 3));
      if (sel == 0) q = 4'd15;
      else if (sel == 1) q = 4'd0;
      else q = 4'($urandom_range(0, 15));
      applyStimulus(r, q);
    end

    @(negedge clki);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
